// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 24-bit noise LFSR stream (taps MSB ^ MSB-1, shift left).
// Define LFSR_CHECK_BITERR_EN to accumulate the number of differing bits per counted mismatch.
module lfsr_checker #(
  parameter int WIDTH      = 24,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    clear,
  output logic                    locked,
  output logic [1:0]              state,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        sample_count,
  output logic [CNT_W-1:0]        bit_err_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_SLIP   = 2'd3
  } state_e;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-2]};
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pred_q, pred_d;
  logic [7:0]         match_q, match_d;
  logic [7:0]         miss_q, miss_d;
  logic               mismatch_q, mismatch_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;

  logic [WIDTH-1:0]   smp;
  logic               hit;
  logic               count_en;
  logic               err_en;
  logic [7:0]         match_inc;
  logic [7:0]         miss_inc;

  assign smp       = sample_in;
  assign hit       = (smp == pred_q);
  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    match_d    = match_q;
    miss_d     = miss_q;
    mismatch_d = 1'b0;
    count_en   = 1'b0;
    err_en     = 1'b0;
    if (sample_valid) begin
      // Always re-seed from the received sample, never from our own prediction.
      pred_d = lfsr_next(smp);
      unique case (state_q)
        ST_HUNT: begin
          if (smp != '0) begin
            state_d = ST_VERIFY;
            match_d = 8'd0;
          end
        end
        ST_VERIFY: begin
          if (hit) begin
            if (match_inc == 8'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              match_d = 8'd0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            mismatch_d = 1'b1;
            match_d    = 8'd0;
            if (smp == '0) state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          count_en = 1'b1;
          if (!hit) begin
            mismatch_d = 1'b1;
            err_en     = 1'b1;
            miss_d     = 8'd1;
            state_d    = (LOSS_COUNT == 1) ? ST_HUNT : ST_SLIP;
          end
        end
        ST_SLIP: begin
          count_en = 1'b1;
          if (hit) begin
            miss_d  = 8'd0;
            state_d = ST_LOCKED;
          end else begin
            mismatch_d = 1'b1;
            err_en     = 1'b1;
            if (miss_inc >= 8'(LOSS_COUNT)) begin
              miss_d  = 8'd0;
              state_d = ST_HUNT;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Counters saturate at all-ones; clear overrides any increment in the same cycle.
  always_comb begin
    err_d  = err_q;
    scnt_d = scnt_q;
    if (clear) begin
      err_d  = '0;
      scnt_d = '0;
    end else begin
      if (err_en && err_q != '1)    err_d  = err_q + 1'b1;
      if (count_en && scnt_q != '1) scnt_d = scnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      pred_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      scnt_q     <= scnt_d;
    end
  end

`ifdef LFSR_CHECK_BITERR_EN
  localparam int PW = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    pop;
  logic [CNT_W:0]   bit_sum;

  assign diff = smp ^ pred_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(diff[i]);
  end

  assign bit_sum = {1'b0, bit_q} + (CNT_W + 1)'(pop);

  always_comb begin
    bit_d = bit_q;
    if (clear)       bit_d = '0;
    else if (err_en) bit_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bit_q <= '0;
    else        bit_q <= bit_d;
  end

  assign bit_err_count = bit_q;
`else
  assign bit_err_count = '0;
`endif

  assign state        = state_q;
  assign locked       = (state_q == ST_LOCKED) || (state_q == ST_SLIP);
  assign mismatch     = mismatch_q;
  assign err_count    = err_q;
  assign sample_count = scnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single-sample slip, loss of lock, zero input,
// counter saturation (narrow-counter instance), clear, and asynchronous reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        clear;

  logic        locked, mismatch;
  logic [1:0]  state;
  logic [15:0] err_count, sample_count, bit_err_count;

  logic        n_locked, n_mismatch;
  logic [1:0]  n_state;
  logic [7:0]  n_err, n_scnt, n_bit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .locked(locked), .state(state), .mismatch(mismatch),
    .err_count(err_count), .sample_count(sample_count), .bit_err_count(bit_err_count)
  );

  lfsr_checker #(.CNT_W(8)) dut_narrow (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .locked(n_locked), .state(n_state), .mismatch(n_mismatch),
    .err_count(n_err), .sample_count(n_scnt), .bit_err_count(n_bit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] nxt(input logic [23:0] x);
    return {x[22:0], x[23] ^ x[22]};
  endfunction

  task automatic send(input logic [23:0] s, input logic clr);
    sample_in    = s;
    sample_valid = 1'b1;
    clear        = clr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic clear_only();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [23:0] cur, y1, y2;
  logic [15:0] exp_bits;

  initial begin
    reset = 1'b0; sample_in = '0; sample_valid = 1'b0; clear = 1'b0;
    #22;
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err", err_count, 0);
    check("rst_scnt", sample_count, 0);
    check("rst_bits", bit_err_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Acquire: seed 1 then four true successors.
    send(24'h000001, 0); check("seed_state", state, 1);
    send(24'h000002, 0);
    send(24'h000004, 0);
    send(24'h000008, 0); check("verify_state", state, 1);
    send(24'h000010, 0);
    check("lock_state", state, 2);
    check("lock_locked", locked, 1);
    check("lock_err", err_count, 0);
    check("lock_scnt", sample_count, 0);
    check("lock_mismatch", mismatch, 0);

    // Single corrupted sample costs exactly two mismatches.
    send(24'h000020, 0); check("locked_match_mm", mismatch, 0);
    send(24'h000041, 0);
    check("slip1_state", state, 3); check("slip1_mm", mismatch, 1); check("slip1_locked", locked, 1);
    send(24'h000080, 0);
    check("slip2_state", state, 3); check("slip2_mm", mismatch, 1); check("slip2_err", err_count, 2);
    send(24'h000100, 0);
    check("relock_state", state, 2); check("relock_mm", mismatch, 0);
    check("relock_err", err_count, 2); check("relock_scnt", sample_count, 4);
`ifdef LFSR_CHECK_BITERR_EN
    check("slip_bits", bit_err_count, 2);
`else
    check("slip_bits", bit_err_count, 0);
`endif

    // Loss of lock after three unrelated samples.
    clear_only();
    check("clr_err", err_count, 0); check("clr_scnt", sample_count, 0); check("clr_state", state, 2);
    send(24'h123456, 0); check("loss1_state", state, 3);
    send(24'h0ABCDE, 0); check("loss2_state", state, 3);
    send(24'h55AA55, 0);
    check("loss3_state", state, 0); check("loss3_locked", locked, 0);
    check("loss3_err", err_count, 3); check("loss3_scnt", sample_count, 3); check("loss3_mm", mismatch, 1);

    // Zero samples never seed and never flag.
    for (int i = 0; i < 4; i++) begin
      send(24'h000000, 0);
      check("zero_state", state, 0);
      check("zero_mm", mismatch, 0);
    end

    // Relock, then a long error run: two errors per three samples.
    send(24'h000001, 0); send(24'h000002, 0); send(24'h000004, 0);
    send(24'h000008, 0); send(24'h000010, 0);
    check("relock2_state", state, 2);
    clear_only();
    cur = 24'h000010;
    for (int i = 0; i < 150; i++) begin
      y1 = nxt(cur) ^ 24'h1;
      y2 = nxt(y1) ^ 24'h1;
      send(y1, 0);
      send(y2, 0);
      send(nxt(y2), 0);
      cur = nxt(y2);
    end
    check("run_state", state, 2);
    check("run_err", err_count, 300);
    check("run_scnt", sample_count, 450);
    check("sat_err", n_err, 8'hFF);
    check("sat_scnt", n_scnt, 8'hFF);
`ifdef LFSR_CHECK_BITERR_EN
    exp_bits = 16'd300;
    check("sat_bits", n_bit, 8'hFF);
`else
    exp_bits = 16'd0;
    check("sat_bits", n_bit, 8'h00);
`endif
    check("run_bits", bit_err_count, exp_bits);

    y1 = nxt(cur) ^ 24'h1;
    send(y1, 0);
    check("hold_err", n_err, 8'hFF);
    check("more_err", err_count, 301);

    // Clear together with a (mismatching) sample: counts zero, state still advances.
    y2 = nxt(y1) ^ 24'h1;
    send(y2, 1);
    check("clrv_err", err_count, 0); check("clrv_scnt", sample_count, 0);
    check("clrv_bits", bit_err_count, 0); check("clrv_nerr", n_err, 0);
    check("clrv_state", state, 3); check("clrv_mm", mismatch, 1);
    send(nxt(y2), 0);
    check("post_clr_state", state, 2); check("post_clr_scnt", sample_count, 1);
    check("post_clr_err", err_count, 0);

    // Asynchronous reset between clock edges while locked.
    #2 reset = 1'b0;
    #1;
    check("arst_state", state, 0); check("arst_locked", locked, 0);
    check("arst_scnt", sample_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    send(24'h000001, 0); send(24'h000002, 0); send(24'h000004, 0); send(24'h000008, 0);
    check("arelock_verify", state, 1);
    send(24'h000010, 0);
    check("arelock_state", state, 2); check("arelock_locked", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
